// File: rtl/execute_stage_md.sv
// EX stage with EX/MEM pipeline register: operand forwarding, single-cycle ALU and an
// iterative RV32M-style multiply/divide unit that holds off the front end while busy.
module execute_stage_md #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_e,
    output logic              ready_e,
    input  logic [3:0]        alu_ctrl_e,
    input  logic              md_en_e,
    input  logic [2:0]        md_op_e,
    input  logic [XLEN-1:0]   rd1_e,
    input  logic [XLEN-1:0]   rd2_e,
    input  logic [1:0]        fwd_a_e,
    input  logic [1:0]        fwd_b_e,
    input  logic [XLEN-1:0]   result_w,
    input  logic [XLEN-1:0]   result_f,
    input  logic [REG_AW-1:0] rd_e,
    input  logic              reg_write_e,
    input  logic [XLEN-1:0]   pc_plus4_e,
    input  logic              stall_m,
    input  logic              flush,
    output logic              valid_m,
    output logic              reg_write_m,
    output logic [REG_AW-1:0] rd_m,
    output logic [XLEN-1:0]   alu_result_m,
    output logic [XLEN-1:0]   write_data_m,
    output logic [XLEN-1:0]   pc_plus4_m,
    output logic              busy
);
    localparam int SHW = $clog2(XLEN);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

    state_t              state_q;
    logic [SHW-1:0]      cnt_q;
    logic [2*XLEN-1:0]   acc_q;
    logic [XLEN-1:0]     mag_q;
    logic [XLEN-1:0]     a_orig_q;
    logic                neg_q;
    logic                sa_q;
    logic                bz_q;
    logic [2:0]          op_q;
    logic [REG_AW-1:0]   rd_md_q;
    logic                rw_md_q;
    logic [XLEN-1:0]     pc_md_q;

    logic [XLEN-1:0]     src_a, src_b, alu_res;
    logic [SHW-1:0]      shamt;
    logic                a_signed, b_signed, sa_d, sb_d;
    logic [XLEN-1:0]     mag_a_d, mag_b_d;
    logic [XLEN:0]       mul_sum;
    logic [2*XLEN-1:0]   mul_next, div_next, prod;
    logic [XLEN:0]       div_shift, div_diff;
    logic [XLEN-1:0]     q_mag, r_mag, md_result;

    assign ready_e = (state_q == S_IDLE) && !stall_m;
    assign busy    = (state_q != S_IDLE);

    always_comb begin
        case (fwd_a_e)
            2'd0:    src_a = rd1_e;
            2'd1:    src_a = result_w;
            2'd2:    src_a = alu_result_m;
            default: src_a = result_f;
        endcase
        case (fwd_b_e)
            2'd0:    src_b = rd2_e;
            2'd1:    src_b = result_w;
            2'd2:    src_b = alu_result_m;
            default: src_b = result_f;
        endcase
    end

    assign shamt = src_b[SHW-1:0];

    always_comb begin
        case (alu_ctrl_e)
            4'd0:    alu_res = src_a + src_b;
            4'd1:    alu_res = src_a - src_b;
            4'd2:    alu_res = src_a & src_b;
            4'd3:    alu_res = src_a | src_b;
            4'd4:    alu_res = src_a ^ src_b;
            4'd5:    alu_res = src_a << shamt;
            4'd6:    alu_res = src_a >> shamt;
            4'd7:    alu_res = $signed(src_a) >>> shamt;
            4'd8:    alu_res = {{(XLEN-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
            4'd9:    alu_res = {{(XLEN-1){1'b0}}, (src_a < src_b)};
            default: alu_res = '0;
        endcase
    end

    // Operands are reduced to magnitudes up front; signs are reapplied when the result is taken.
    always_comb begin
        a_signed = (md_op_e == 3'd0) || (md_op_e == 3'd1) || (md_op_e == 3'd2) ||
                   (md_op_e == 3'd4) || (md_op_e == 3'd6);
        b_signed = (md_op_e == 3'd0) || (md_op_e == 3'd1) ||
                   (md_op_e == 3'd4) || (md_op_e == 3'd6);
        sa_d     = a_signed && src_a[XLEN-1];
        sb_d     = b_signed && src_b[XLEN-1];
        mag_a_d  = sa_d ? ('0 - src_a) : src_a;
        mag_b_d  = sb_d ? ('0 - src_b) : src_b;
    end

    always_comb begin
        mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, mag_q} : '0);
        mul_next  = {mul_sum, acc_q[XLEN-1:1]};
        div_shift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
        div_diff  = div_shift - {1'b0, mag_q};
        div_next  = div_diff[XLEN] ? {div_shift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                                   : {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
    end

    always_comb begin
        prod  = neg_q ? ('0 - acc_q) : acc_q;
        q_mag = acc_q[XLEN-1:0];
        r_mag = acc_q[2*XLEN-1:XLEN];
        case (op_q)
            3'd0:       md_result = prod[XLEN-1:0];
            3'd1, 3'd2,
            3'd3:       md_result = prod[2*XLEN-1:XLEN];
            3'd4, 3'd5: md_result = bz_q ? '1 : (neg_q ? ('0 - q_mag) : q_mag);
            default:    md_result = bz_q ? a_orig_q : (sa_q ? ('0 - r_mag) : r_mag);
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            acc_q        <= '0;
            mag_q        <= '0;
            a_orig_q     <= '0;
            neg_q        <= 1'b0;
            sa_q         <= 1'b0;
            bz_q         <= 1'b0;
            op_q         <= '0;
            rd_md_q      <= '0;
            rw_md_q      <= 1'b0;
            pc_md_q      <= '0;
            valid_m      <= 1'b0;
            reg_write_m  <= 1'b0;
            rd_m         <= '0;
            alu_result_m <= '0;
            write_data_m <= '0;
            pc_plus4_m   <= '0;
        end else if (flush) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            valid_m     <= 1'b0;
            reg_write_m <= 1'b0;
        end else begin
            // Iteration keeps running under a downstream stall; only DONE waits.
            if (state_q == S_MUL || state_q == S_DIV) begin
                acc_q <= (state_q == S_MUL) ? mul_next : div_next;
                if (cnt_q == SHW'(XLEN-1)) begin
                    cnt_q   <= '0;
                    state_q <= S_DONE;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end
            if (!stall_m) begin
                valid_m     <= 1'b0;
                reg_write_m <= 1'b0;
                case (state_q)
                    S_IDLE: begin
                        if (valid_e && md_en_e) begin
                            op_q     <= md_op_e;
                            rd_md_q  <= rd_e;
                            rw_md_q  <= reg_write_e;
                            pc_md_q  <= pc_plus4_e;
                            a_orig_q <= src_a;
                            sa_q     <= sa_d;
                            neg_q    <= sa_d ^ sb_d;
                            bz_q     <= (src_b == '0);
                            cnt_q    <= '0;
                            if (md_op_e[2]) begin
                                acc_q   <= {{XLEN{1'b0}}, mag_a_d};
                                mag_q   <= mag_b_d;
                                state_q <= S_DIV;
                            end else begin
                                acc_q   <= {{XLEN{1'b0}}, mag_b_d};
                                mag_q   <= mag_a_d;
                                state_q <= S_MUL;
                            end
                        end else if (valid_e) begin
                            valid_m      <= 1'b1;
                            reg_write_m  <= reg_write_e;
                            rd_m         <= rd_e;
                            alu_result_m <= alu_res;
                            write_data_m <= src_b;
                            pc_plus4_m   <= pc_plus4_e;
                        end
                    end
                    S_DONE: begin
                        valid_m      <= 1'b1;
                        reg_write_m  <= rw_md_q;
                        rd_m         <= rd_md_q;
                        alu_result_m <= md_result;
                        pc_plus4_m   <= pc_md_q;
                        state_q      <= S_IDLE;
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_execute_stage_md.sv
// Directed bench for execute_stage_md: ALU, forwarding, MUL/DIV results and latency,
// stall in DONE, flush of an in-flight divide and asynchronous reset mid-multiply.
module tb_execute_stage_md;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid_e = 1'b0;
    logic        ready_e;
    logic [3:0]  alu_ctrl_e = '0;
    logic        md_en_e = 1'b0;
    logic [2:0]  md_op_e = '0;
    logic [31:0] rd1_e = '0, rd2_e = '0;
    logic [1:0]  fwd_a_e = '0, fwd_b_e = '0;
    logic [31:0] result_w = '0, result_f = '0;
    logic [4:0]  rd_e = 5'd9;
    logic        reg_write_e = 1'b1;
    logic [31:0] pc_plus4_e = 32'h0000_1004;
    logic        stall_m = 1'b0, flush = 1'b0;
    logic        valid_m, reg_write_m, busy;
    logic [4:0]  rd_m;
    logic [31:0] alu_result_m, write_data_m, pc_plus4_m;

    int n_vec = 0;
    int n_miss = 0;

    execute_stage_md #(.XLEN(32), .REG_AW(5)) dut (
        .clk(clk), .rst(rst), .valid_e(valid_e), .ready_e(ready_e),
        .alu_ctrl_e(alu_ctrl_e), .md_en_e(md_en_e), .md_op_e(md_op_e),
        .rd1_e(rd1_e), .rd2_e(rd2_e), .fwd_a_e(fwd_a_e), .fwd_b_e(fwd_b_e),
        .result_w(result_w), .result_f(result_f), .rd_e(rd_e), .reg_write_e(reg_write_e),
        .pc_plus4_e(pc_plus4_e), .stall_m(stall_m), .flush(flush),
        .valid_m(valid_m), .reg_write_m(reg_write_m), .rd_m(rd_m),
        .alu_result_m(alu_result_m), .write_data_m(write_data_m), .pc_plus4_m(pc_plus4_m),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Presents one instruction for exactly one rising edge; returns 1 ns after that edge.
    task automatic issue(input logic md, input logic [3:0] alu, input logic [2:0] op,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [1:0] fa, input logic [1:0] fb);
        valid_e = 1'b1; md_en_e = md; alu_ctrl_e = alu; md_op_e = op;
        rd1_e = a; rd2_e = b; fwd_a_e = fa; fwd_b_e = fb;
        @(posedge clk); #1;
        valid_e = 1'b0; md_en_e = 1'b0; fwd_a_e = 2'd0; fwd_b_e = 2'd0;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (valid_m !== 1'b1 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic test_reset();
        #2 rst = 1'b0;
        #1;
        n_vec++;
        if ({valid_m, reg_write_m, busy, rd_m} !== 8'h0) begin
            n_miss++; $display("FAIL reset_ctrl: v/rw/busy/rd=%b want 0", {valid_m, reg_write_m, busy, rd_m});
        end
        n_vec++;
        if ({alu_result_m, write_data_m, pc_plus4_m} !== 96'h0) begin
            n_miss++; $display("FAIL reset_data: %h %h %h want 0", alu_result_m, write_data_m, pc_plus4_m);
        end
        n_vec++;
        if (ready_e !== 1'b1) begin
            n_miss++; $display("FAIL reset_ready: ready_e=%b want 1", ready_e);
        end
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        $display("txn reset released");
    endtask

    task automatic test_add_fwd();
        issue(1'b0, 4'd0, 3'd0, 32'h10, 32'h0, 2'd0, 2'd0);
        n_vec++;
        if (alu_result_m !== 32'h10) begin
            n_miss++; $display("FAIL add_setup: alu_result_m=%h want 00000010", alu_result_m);
        end
        issue(1'b0, 4'd0, 3'd0, 32'h5, 32'h3, 2'd2, 2'd0);
        $display("txn add fwd_a=2 -> %h", alu_result_m);
        n_vec++;
        if (alu_result_m !== 32'h13 || valid_m !== 1'b1) begin
            n_miss++; $display("FAIL add_fwd: result=%h valid=%b want 00000013/1", alu_result_m, valid_m);
        end
        n_vec++;
        if (write_data_m !== 32'h3 || rd_m !== 5'd9 || pc_plus4_m !== 32'h1004 || reg_write_m !== 1'b1) begin
            n_miss++; $display("FAIL add_fields: wd=%h rd=%0d pc=%h rw=%b want 3/9/1004/1",
                               write_data_m, rd_m, pc_plus4_m, reg_write_m);
        end
        @(posedge clk); #1;
        n_vec++;
        if (valid_m !== 1'b0) begin
            n_miss++; $display("FAIL bubble: valid_m=%b want 0", valid_m);
        end
    endtask

    task automatic test_alu();
        logic [3:0]  ops [11] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10, 4'd15};
        logic [31:0] as  [11] = '{32'h3, 32'hF0F0F0F0, 32'hF0, 32'hFFFF0000, 32'h1, 32'h80000000,
                                  32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h1234, 32'h1};
        logic [31:0] bs  [11] = '{32'h5, 32'h0FF00FF0, 32'h0F, 32'h0F0F0F0F, 32'h23, 32'h4,
                                  32'h4, 32'h1, 32'h1, 32'h1, 32'h1};
        logic [31:0] ex  [11] = '{32'hFFFFFFFE, 32'h00F000F0, 32'hFF, 32'hF0F00F0F, 32'h8, 32'h08000000,
                                  32'hF8000000, 32'h1, 32'h0, 32'h0, 32'h0};
        for (int i = 0; i < 11; i++) begin
            issue(1'b0, ops[i], 3'd0, as[i], bs[i], 2'd0, 2'd0);
            $display("txn alu op=%0d a=%h b=%h -> %h", ops[i], as[i], bs[i], alu_result_m);
            n_vec++;
            if (alu_result_m !== ex[i] || valid_m !== 1'b1) begin
                n_miss++; $display("FAIL alu_op%0d: result=%h valid=%b want %h/1", ops[i], alu_result_m, valid_m, ex[i]);
            end
        end
        result_w = 32'h100; result_f = 32'h23;
        issue(1'b0, 4'd0, 3'd0, 32'hDEAD, 32'hBEEF, 2'd1, 2'd3);
        $display("txn add fwd w/f -> %h", alu_result_m);
        n_vec++;
        if (alu_result_m !== 32'h123 || write_data_m !== 32'h23) begin
            n_miss++; $display("FAIL fwd_wf: result=%h wd=%h want 00000123/00000023", alu_result_m, write_data_m);
        end
    endtask

    task automatic test_back_to_back();
        issue(1'b0, 4'd0, 3'd0, 32'h1, 32'h2, 2'd0, 2'd0);
        issue(1'b0, 4'd1, 3'd0, 32'h0, 32'h1, 2'd2, 2'd0);
        n_vec++;
        if (alu_result_m !== 32'h2 || valid_m !== 1'b1) begin
            n_miss++; $display("FAIL b2b_sub: result=%h valid=%b want 00000002/1", alu_result_m, valid_m);
        end
        issue(1'b0, 4'd2, 3'd0, 32'hFF, 32'h0, 2'd0, 2'd2);
        $display("txn back-to-back -> %h", alu_result_m);
        n_vec++;
        if (alu_result_m !== 32'h2 || valid_m !== 1'b1) begin
            n_miss++; $display("FAIL b2b_and: result=%h valid=%b want 00000002/1", alu_result_m, valid_m);
        end
    endtask

    task automatic test_mulhu_latency();
        int n = 0;
        int busy_cycles = 0;
        issue(1'b1, 4'd0, 3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 2'd0, 2'd0);
        while (valid_m !== 1'b1 && n < 100) begin
            if (ready_e === 1'b0) busy_cycles++;
            @(posedge clk); #1;
            n++;
        end
        $display("txn mulhu -> %h after %0d edges", alu_result_m, n);
        n_vec++;
        if (n != 33) begin
            n_miss++; $display("FAIL mulhu_latency: edges=%0d want 33", n);
        end
        n_vec++;
        if (busy_cycles != 33) begin
            n_miss++; $display("FAIL mulhu_ready: not-ready cycles=%0d want 33", busy_cycles);
        end
        n_vec++;
        if (alu_result_m !== 32'hFFFFFFFE || ready_e !== 1'b1 || busy !== 1'b0) begin
            n_miss++; $display("FAIL mulhu_result: result=%h ready=%b busy=%b want fffffffe/1/0",
                               alu_result_m, ready_e, busy);
        end
    endtask

    task automatic test_md_table();
        logic [2:0]  ops [16] = '{3'd0, 3'd1, 3'd0, 3'd2, 3'd3, 3'd1,
                                  3'd4, 3'd6, 3'd4, 3'd6, 3'd4, 3'd6, 3'd5, 3'd7, 3'd5, 3'd7};
        logic [31:0] as  [16] = '{32'hFFFFFFFF, 32'hFFFFFFFE, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h10000, 32'h80000000,
                                  32'h7, 32'h7, 32'h80000000, 32'h80000000, 32'hFFFFFFF9, 32'hFFFFFFF9,
                                  32'd100, 32'd100, 32'hFFFFFFFF, 32'h5};
        logic [31:0] bs  [16] = '{32'hFFFFFFFF, 32'h3, 32'h3, 32'hFFFFFFFF, 32'h10000, 32'h80000000,
                                  32'h0, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h2, 32'h2,
                                  32'd7, 32'd7, 32'h0, 32'h0};
        logic [31:0] ex  [16] = '{32'h1, 32'hFFFFFFFF, 32'hFFFFFFFA, 32'hFFFFFFFF, 32'h1, 32'h40000000,
                                  32'hFFFFFFFF, 32'h7, 32'h80000000, 32'h0, 32'hFFFFFFFD, 32'hFFFFFFFF,
                                  32'd14, 32'd2, 32'hFFFFFFFF, 32'h5};
        int n;
        for (int i = 0; i < 16; i++) begin
            issue(1'b1, 4'd0, ops[i], as[i], bs[i], 2'd0, 2'd0);
            wait_valid(n);
            $display("txn md op=%0d a=%h b=%h -> %h", ops[i], as[i], bs[i], alu_result_m);
            n_vec++;
            if (alu_result_m !== ex[i] || valid_m !== 1'b1 || n != 33) begin
                n_miss++; $display("FAIL md_op%0d_%0d: result=%h valid=%b edges=%0d want %h/1/33",
                                   ops[i], i, alu_result_m, valid_m, n, ex[i]);
            end
        end
    endtask

    task automatic test_stall_done();
        logic [31:0] snap;
        issue(1'b1, 4'd0, 3'd0, 32'd6, 32'd7, 2'd0, 2'd0);
        repeat (32) begin @(posedge clk); #1; end
        n_vec++;
        if (valid_m !== 1'b0 || busy !== 1'b1) begin
            n_miss++; $display("FAIL stall_pre: valid=%b busy=%b want 0/1", valid_m, busy);
        end
        snap = alu_result_m;
        stall_m = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            n_vec++;
            if (valid_m !== 1'b0 || alu_result_m !== snap || ready_e !== 1'b0 || busy !== 1'b1) begin
                n_miss++; $display("FAIL stall_hold%0d: valid=%b result=%h ready=%b busy=%b want 0/%h/0/1",
                                   k, valid_m, alu_result_m, ready_e, busy, snap);
            end
        end
        stall_m = 1'b0;
        @(posedge clk); #1;
        $display("txn mul after stall -> %h", alu_result_m);
        n_vec++;
        if (valid_m !== 1'b1 || alu_result_m !== 32'd42) begin
            n_miss++; $display("FAIL stall_release: valid=%b result=%h want 1/0000002a", valid_m, alu_result_m);
        end
    endtask

    task automatic test_flush();
        int hits = 0;
        issue(1'b1, 4'd0, 3'd5, 32'd1000, 32'd3, 2'd0, 2'd0);
        repeat (10) begin @(posedge clk); #1; end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        n_vec++;
        if (busy !== 1'b0 || valid_m !== 1'b0 || reg_write_m !== 1'b0 || ready_e !== 1'b1) begin
            n_miss++; $display("FAIL flush_state: busy=%b valid=%b rw=%b ready=%b want 0/0/0/1",
                               busy, valid_m, reg_write_m, ready_e);
        end
        issue(1'b0, 4'd0, 3'd0, 32'd2, 32'd2, 2'd0, 2'd0);
        $display("txn add after flush -> %h", alu_result_m);
        n_vec++;
        if (valid_m !== 1'b1 || alu_result_m !== 32'd4) begin
            n_miss++; $display("FAIL flush_add: valid=%b result=%h want 1/00000004", valid_m, alu_result_m);
        end
        repeat (40) begin
            @(posedge clk); #1;
            if (valid_m === 1'b1) hits++;
        end
        n_vec++;
        if (hits != 0) begin
            n_miss++; $display("FAIL flush_ghost: %0d stray valid_m cycles want 0", hits);
        end
    endtask

    task automatic test_async_reset();
        int n;
        issue(1'b1, 4'd0, 3'd0, 32'd123, 32'd456, 2'd0, 2'd0);
        repeat (5) begin @(posedge clk); #1; end
        #2 rst = 1'b0;
        #1;
        n_vec++;
        if (busy !== 1'b0 || valid_m !== 1'b0 || reg_write_m !== 1'b0 || rd_m !== 5'd0 ||
            alu_result_m !== 32'h0 || write_data_m !== 32'h0 || pc_plus4_m !== 32'h0) begin
            n_miss++; $display("FAIL async_rst: busy=%b valid=%b rw=%b rd=%0d res=%h wd=%h pc=%h want all 0",
                               busy, valid_m, reg_write_m, rd_m, alu_result_m, write_data_m, pc_plus4_m);
        end
        #2 rst = 1'b1;
        @(posedge clk); #1;
        issue(1'b1, 4'd0, 3'd0, 32'd6, 32'd7, 2'd0, 2'd0);
        wait_valid(n);
        $display("txn mul after reset -> %h", alu_result_m);
        n_vec++;
        if (alu_result_m !== 32'd42 || valid_m !== 1'b1 || n != 33) begin
            n_miss++; $display("FAIL post_rst_mul: result=%h valid=%b edges=%0d want 0000002a/1/33",
                               alu_result_m, valid_m, n);
        end
    endtask

    initial begin
        test_reset();
        test_add_fwd();
        test_alu();
        test_back_to_back();
        test_mulhu_latency();
        test_md_table();
        test_stall_done();
        test_flush();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
